// File: rtl/rotary_counter.sv
// rotary_counter: bounded position accumulator for decoded encoder steps with
// saturate/wrap range handling, optional time-based acceleration and load.
module rotary_counter #(
    parameter int WIDTH           = 8,
    parameter int MIN_VALUE       = 0,
    parameter int MAX_VALUE       = 255,
    parameter int RESET_VALUE     = 0,
    parameter bit WRAP            = 0,
    parameter int ACCEL_WINDOW    = 0,
    parameter int ACCEL_MAX_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_cw,
    input  logic             in_ccw,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             changed,
    output logic             direction,
    output logic             at_limit
);
    localparam int SW = ACCEL_MAX_SHIFT > 0 ? $clog2(ACCEL_MAX_SHIFT + 1) : 1;
    localparam int TW = ACCEL_WINDOW > 0 ? $clog2(ACCEL_WINDOW + 1) : 1;
    localparam logic [TW-1:0] WIN = TW'(ACCEL_WINDOW);
    localparam logic [SW-1:0] SMAX = SW'(ACCEL_MAX_SHIFT);
    localparam logic signed [WIDTH+1:0] LO = (WIDTH+2)'(MIN_VALUE);
    localparam logic signed [WIDTH+1:0] HI = (WIDTH+2)'(MAX_VALUE);
    localparam logic signed [WIDTH+1:0] SPAN = (WIDTH+2)'(MAX_VALUE - MIN_VALUE + 1);
    localparam logic [WIDTH-1:0] VMIN = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] VMAX = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] VRST = WIDTH'(RESET_VALUE);
    localparam logic AT_RST = !WRAP && (RESET_VALUE == MIN_VALUE || RESET_VALUE == MAX_VALUE);

    logic [WIDTH-1:0] value_q, value_d;
    logic             changed_q, changed_d;
    logic             direction_q, direction_d;
    logic             at_limit_q, at_limit_d;
    logic [SW-1:0]    shift_q, shift_d, shift_nxt;
    logic [TW-1:0]    timer_q, timer_d;
    logic             step, accel;
    logic signed [WIDTH+1:0] cur, stepv, cand, stepped, lv, clamped;

    always_comb begin
        step      = in_cw ^ in_ccw;
        accel     = ACCEL_WINDOW > 0 && direction_q == in_cw && timer_q < WIN;
        shift_nxt = accel ? (shift_q == SMAX ? shift_q : shift_q + 1'b1) : '0;
        stepv     = {{(WIDTH+1){1'b0}}, 1'b1} << shift_nxt;
        cur       = {2'b00, value_q};
        cand      = in_cw ? cur + stepv : cur - stepv;
        // One wrap correction suffices since the largest step never exceeds the span.
        stepped   = WRAP ? (cand > HI ? cand - SPAN : cand < LO ? cand + SPAN : cand)
                         : (cand > HI ? HI : cand < LO ? LO : cand);
        lv        = {2'b00, load_value};
        clamped   = lv > HI ? HI : lv < LO ? LO : lv;
        value_d   = load ? clamped[WIDTH-1:0] : step ? stepped[WIDTH-1:0] : value_q;
        changed_d = value_d != value_q;
        direction_d = !load && step ? in_cw : direction_q;
        shift_d   = load ? '0 : step ? shift_nxt : shift_q;
        timer_d   = load ? WIN : step ? '0 : (timer_q == WIN ? timer_q : timer_q + 1'b1);
        at_limit_d = !WRAP && (value_d == VMIN || value_d == VMAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q     <= VRST;
            changed_q   <= 1'b0;
            direction_q <= 1'b0;
            at_limit_q  <= AT_RST;
            shift_q     <= '0;
            timer_q     <= WIN;
        end else begin
            value_q     <= value_d;
            changed_q   <= changed_d;
            direction_q <= direction_d;
            at_limit_q  <= at_limit_d;
            shift_q     <= shift_d;
            timer_q     <= timer_d;
        end
    end

    assign value     = value_q;
    assign changed   = changed_q;
    assign direction = direction_q;
    assign at_limit  = at_limit_q;
endmodule

// File: tb/tb_rotary_counter.sv
// tb_rotary_counter: directed vectors over saturating, wrapping, accelerating
// and load-clamping configurations sharing one input stream.
module tb_rotary_counter;
    logic clk = 1'b0, rst = 1'b0, in_cw = 1'b0, in_ccw = 1'b0, load = 1'b0;
    logic [7:0] load_value = '0;
    logic [7:0] a_v, b_v, c_v, d_v;
    logic a_ch, a_dir, a_lim, b_ch, b_dir, b_lim, c_ch, c_dir, c_lim, d_ch, d_dir, d_lim;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    rotary_counter #(.WIDTH(8), .MAX_VALUE(9)) dut_a (
        .clk(clk), .rst(rst), .in_cw(in_cw), .in_ccw(in_ccw), .load(load), .load_value(load_value),
        .value(a_v), .changed(a_ch), .direction(a_dir), .at_limit(a_lim));
    rotary_counter #(.WIDTH(8), .MAX_VALUE(9), .WRAP(1)) dut_b (
        .clk(clk), .rst(rst), .in_cw(in_cw), .in_ccw(in_ccw), .load(load), .load_value(load_value),
        .value(b_v), .changed(b_ch), .direction(b_dir), .at_limit(b_lim));
    rotary_counter #(.WIDTH(8), .MAX_VALUE(255), .ACCEL_WINDOW(10), .ACCEL_MAX_SHIFT(2)) dut_c (
        .clk(clk), .rst(rst), .in_cw(in_cw), .in_ccw(in_ccw), .load(load), .load_value(load_value),
        .value(c_v), .changed(c_ch), .direction(c_dir), .at_limit(c_lim));
    rotary_counter #(.WIDTH(8), .MAX_VALUE(99)) dut_d (
        .clk(clk), .rst(rst), .in_cw(in_cw), .in_ccw(in_ccw), .load(load), .load_value(load_value),
        .value(d_v), .changed(d_ch), .direction(d_dir), .at_limit(d_lim));

    // in = {rst, cw, ccw, load}; o = {changed, direction, at_limit}
    typedef struct {
        logic [3:0] in;
        logic [7:0] lv;
        logic [7:0] v;
        logic [2:0] o;
    } vec_t;
    vec_t tbl[21];

    function automatic vec_t mk(logic [3:0] in, logic [7:0] lv, logic [7:0] v, logic [2:0] o);
        vec_t r;
        r.in = in; r.lv = lv; r.v = v; r.o = o;
        return r;
    endfunction

    task automatic chk(string n, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic drive(logic [3:0] i, logic [7:0] lv);
        {rst, in_cw, in_ccw, load} = i;
        load_value = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drive(4'b0000, 8'd0);
    endtask

    initial begin
        int ea[5] = '{1, 3, 7, 11, 15};
        tbl[0]  = mk(4'b1000, 8'd0,   8'd0, 3'b001);
        tbl[1]  = mk(4'b0100, 8'd0,   8'd1, 3'b110);
        tbl[2]  = mk(4'b0000, 8'd0,   8'd1, 3'b010);
        tbl[3]  = mk(4'b0000, 8'd0,   8'd1, 3'b010);
        tbl[4]  = mk(4'b0000, 8'd0,   8'd1, 3'b010);
        tbl[5]  = mk(4'b0100, 8'd0,   8'd2, 3'b110);
        tbl[6]  = mk(4'b0000, 8'd0,   8'd2, 3'b010);
        tbl[7]  = mk(4'b0000, 8'd0,   8'd2, 3'b010);
        tbl[8]  = mk(4'b0000, 8'd0,   8'd2, 3'b010);
        tbl[9]  = mk(4'b0100, 8'd0,   8'd3, 3'b110);
        tbl[10] = mk(4'b0000, 8'd0,   8'd3, 3'b010);
        tbl[11] = mk(4'b0001, 8'd9,   8'd9, 3'b111);
        tbl[12] = mk(4'b0100, 8'd0,   8'd9, 3'b011);
        tbl[13] = mk(4'b0010, 8'd0,   8'd8, 3'b100);
        tbl[14] = mk(4'b0110, 8'd0,   8'd8, 3'b000);
        tbl[15] = mk(4'b0001, 8'd8,   8'd8, 3'b000);
        tbl[16] = mk(4'b0010, 8'd0,   8'd7, 3'b100);
        tbl[17] = mk(4'b0101, 8'd200, 8'd9, 3'b101);
        tbl[18] = mk(4'b0001, 8'd0,   8'd0, 3'b101);
        tbl[19] = mk(4'b0010, 8'd0,   8'd0, 3'b001);
        tbl[20] = mk(4'b0100, 8'd0,   8'd1, 3'b110);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].in, tbl[i].lv);
            chk($sformatf("sat[%0d].value", i), a_v, tbl[i].v);
            chk($sformatf("sat[%0d].changed", i), a_ch, tbl[i].o[2]);
            chk($sformatf("sat[%0d].direction", i), a_dir, tbl[i].o[1]);
            chk($sformatf("sat[%0d].at_limit", i), a_lim, tbl[i].o[0]);
        end

        drive(4'b1000, 8'd0);
        drive(4'b0001, 8'd9);
        chk("wrap.load9", b_v, 9);
        drive(4'b0100, 8'd0);
        chk("wrap.up.value", b_v, 0);
        chk("wrap.up.changed", b_ch, 1);
        chk("wrap.up.at_limit", b_lim, 0);
        drive(4'b0010, 8'd0);
        chk("wrap.down.value", b_v, 9);
        chk("wrap.down.changed", b_ch, 1);
        chk("wrap.down.at_limit", b_lim, 0);

        drive(4'b1000, 8'd0);
        drive(4'b0101, 8'd200);
        chk("clamp99.value", d_v, 99);
        chk("clamp99.changed", d_ch, 1);
        chk("clamp99.at_limit", d_lim, 1);

        drive(4'b1000, 8'd0);
        for (int k = 0; k < 5; k++) begin
            drive(4'b0100, 8'd0);
            chk($sformatf("accel[%0d].value", k), c_v, ea[k]);
            idle(4);
        end
        idle(20);
        drive(4'b0100, 8'd0);
        chk("accel.slow.value", c_v, 16);
        idle(2);
        drive(4'b0010, 8'd0);
        chk("accel.reverse.value", c_v, 15);
        chk("accel.reverse.direction", c_dir, 0);

        drive(4'b1000, 8'd0);
        drive(4'b0100, 8'd0);
        idle(4);
        drive(4'b0100, 8'd0);
        drive(4'b0100, 8'd0);
        chk("rstseq.shift2.value", c_v, 7);
        idle(1);
        drive(4'b0110, 8'd0);
        chk("rstseq.both.value", c_v, 7);
        chk("rstseq.both.changed", c_ch, 0);
        idle(1);
        drive(4'b0100, 8'd0);
        chk("rstseq.held_accel.value", c_v, 11);
        drive(4'b1000, 8'd0);
        chk("rstseq.rst.value", c_v, 0);
        chk("rstseq.rst.changed", c_ch, 0);
        drive(4'b0100, 8'd0);
        chk("rstseq.after.value", c_v, 1);
        chk("rstseq.after.direction", c_dir, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rotary_counter.md
Name: rotary_counter

Overview:
- Consumer stage directly downstream of the debounced rotary-encoder step decoder.
- Accumulates single-cycle clockwise and counter-clockwise step flags into a bounded WIDTH-bit position value.
- Supports saturating or wrapping range handling and optional time-based acceleration, where fast same-direction turning grows the step size.
- Supports a synchronous load, and drives UI/parameter registers with a one-cycle "changed" strobe.

Parameters:
- WIDTH, 8, width of value and load_value.
- MIN_VALUE, 0, lower bound (inclusive), unsigned.
- MAX_VALUE, 255, upper bound (inclusive), unsigned, > MIN_VALUE.
- RESET_VALUE, 0, value after reset; must lie in [MIN_VALUE, MAX_VALUE].
- WRAP, 0, 0 = saturate at bounds, 1 = wrap modulo (MAX_VALUE-MIN_VALUE+1).
- ACCEL_WINDOW, 0, max cycles between same-direction steps that still accelerate; 0 disables acceleration.
- ACCEL_MAX_SHIFT, 3, max step size is 1<<ACCEL_MAX_SHIFT; must satisfy 1<<ACCEL_MAX_SHIFT <= MAX_VALUE-MIN_VALUE+1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_cw  input  1  one-cycle clockwise step flag.
- in_ccw  input  1  one-cycle counter-clockwise step flag.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value to load; clamped into range.
- value  output  WIDTH  registered position.
- changed  output  1  registered one-cycle strobe; value differs from its previous cycle.
- direction  output  1  registered; 1 = last accepted step was cw, 0 = ccw.
- at_limit  output  1  registered; value==MIN_VALUE or value==MAX_VALUE when WRAP=0; constant 0 when WRAP=1.

Behaviour:
- Reset state: value=RESET_VALUE, changed=0, direction=0, at_limit per RESET_VALUE, accel shift=0, gap timer saturated at ACCEL_WINDOW (so the first step is never accelerated).
- Reset has priority over everything. Reset mid-sequence discards all acceleration history.
- Latency: an input in cycle N is reflected in value/changed/direction/at_limit at cycle N+1. No stalls; a step is accepted every cycle.
- Priority per cycle: rst > load > step > idle.
- Load: value <= clamp(load_value, MIN_VALUE, MAX_VALUE), in both modes. Accel shift <= 0. Gap timer saturated. Any coincident step is dropped.
- Step accepted only when exactly one of in_cw/in_ccw is high. Both high is ignored: no value change, acceleration state untouched, gap timer keeps counting.
- Gap timer counts cycles since the last accepted step and saturates at ACCEL_WINDOW. It clears to 0 on each accepted step.
- On an accepted step:
  - If ACCEL_WINDOW>0, same direction as the previous accepted step, and timer < ACCEL_WINDOW: shift <= min(shift+1, ACCEL_MAX_SHIFT).
  - Otherwise shift <= 0.
  - Step size = 1<<(new shift); the step that triggers acceleration already uses the larger size.
  - direction <= in_cw.
- Arithmetic: computed in a WIDTH+2-bit signed intermediate with no internal overflow. Candidate = value ± step.
  - WRAP=0: candidate clamped to [MIN_VALUE, MAX_VALUE].
  - WRAP=1: candidate > MAX_VALUE gives candidate-span; candidate < MIN_VALUE gives candidate+span, where span = MAX_VALUE-MIN_VALUE+1. A single correction always suffices, given the parameter constraint.
- changed <= 1 only if the new value != current value. Saturating against a bound or reloading the same value gives changed=0.
- Idle cycles: changed <= 0; all other state is held.

Test Plan:
- MAX_VALUE=9, WRAP=0, ACCEL_WINDOW=0: reset, then 3 in_cw pulses 4 cycles apart -> value 0→1→2→3, each one cycle after its pulse, 3 single-cycle changed pulses, direction=1.
- Same config, at value 9: in_cw -> value stays 9, changed=0, at_limit=1. Then in_ccw -> 8, changed=1, at_limit=0, direction=0.
- WRAP=1, MAX_VALUE=9: from 9, in_cw -> 0. in_ccw -> 9. Both pulses: changed=1, at_limit=0.
- ACCEL_WINDOW=10, ACCEL_MAX_SHIFT=2, MAX_VALUE=255: from 0, five in_cw 5 cycles apart -> steps 1,2,4,4,4, value 15. Idle 20 cycles, in_cw -> 16. Then in_ccw 3 cycles later -> 15 (reversal resets to step 1).
- in_cw and in_ccw high in the same cycle -> value unchanged, changed=0. load=1 with load_value=200, MAX_VALUE=99, plus in_cw in the same cycle -> value 99, step dropped.
- Mid-acceleration (shift=2), assert rst for 1 cycle -> value=RESET_VALUE, changed=0. The next in_cw is step 1, even if it falls within ACCEL_WINDOW.
